// File: rtl/bnn_param_loader.sv
// bnn_param_loader: takes parameter bytes over valid/ready and shifts them
// LSB-first into the BNN scan chain. It strobes chain_setup only on cycles
// that carry a real bit, and raises done after exactly CHAIN_BITS shifts.
// Optional feature: define BNN_PARAM_LOADER_VERIFY_EN to add a recirculating
// verify pass that compares the ones count seen on chain_tail with the ones
// count loaded.
module bnn_param_loader #(
  parameter int CHAIN_BITS = 384,
  parameter int CNT_W      = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [7:0]       byte_data,
  input  logic             byte_valid,
  output logic             byte_ready,
  output logic             chain_setup,
  output logic             chain_param,
  input  logic             chain_tail,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] bit_count
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_DONE   = 2'd2
`ifdef BNN_PARAM_LOADER_VERIFY_EN
    , S_VERIFY = 2'd3
`endif
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(CHAIN_BITS - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
`ifdef BNN_PARAM_LOADER_VERIFY_EN
  localparam logic [CNT_W-1:0] TERM = CNT_W'(CHAIN_BITS);
`endif

  state_t           state_reg, state_next;
  logic [7:0]       sr_reg, sr_next;
  logic [3:0]       occ_reg, occ_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             setup_reg, setup_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;
  logic             shift, last_shift;
`ifdef BNN_PARAM_LOADER_VERIFY_EN
  logic             error_reg, error_next;
  logic [CNT_W-1:0] ones_load_reg, ones_load_next;
  logic [CNT_W-1:0] ones_tail_reg, ones_tail_next;
`endif

  // State register and all registered datapath/outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= S_IDLE;
      sr_reg        <= '0;
      occ_reg       <= '0;
      cnt_reg       <= '0;
      setup_reg     <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
`ifdef BNN_PARAM_LOADER_VERIFY_EN
      error_reg     <= 1'b0;
      ones_load_reg <= '0;
      ones_tail_reg <= '0;
`endif
    end else begin
      state_reg     <= state_next;
      sr_reg        <= sr_next;
      occ_reg       <= occ_next;
      cnt_reg       <= cnt_next;
      setup_reg     <= setup_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
`ifdef BNN_PARAM_LOADER_VERIFY_EN
      error_reg     <= error_next;
      ones_load_reg <= ones_load_next;
      ones_tail_reg <= ones_tail_next;
`endif
    end
  end

  // Next-state, shift/accept control and byte_ready (from state only)
  always_comb begin
    state_next = state_reg;
    sr_next    = sr_reg;
    occ_next   = occ_reg;
    cnt_next   = cnt_reg;
    done_next  = done_reg;
`ifdef BNN_PARAM_LOADER_VERIFY_EN
    error_next     = error_reg;
    ones_load_next = ones_load_reg;
    ones_tail_next = ones_tail_reg;
`endif
    // A bit goes out on every LOAD cycle that still holds data.
    shift      = (state_reg == S_LOAD) && (occ_reg != 4'd0);
    last_shift = shift && (cnt_reg == LAST);
    // Ready with one bit left lets the next byte land with no bubble,
    // except on the final shift where remaining data is discarded.
    byte_ready = (state_reg == S_LOAD) && !last_shift &&
                 ((occ_reg == 4'd0) || (occ_reg == 4'd1));

    case (state_reg)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_next = S_LOAD;
          sr_next    = '0;
          occ_next   = '0;
          cnt_next   = '0;
          done_next  = 1'b0;
`ifdef BNN_PARAM_LOADER_VERIFY_EN
          error_next     = 1'b0;
          ones_load_next = '0;
          ones_tail_next = '0;
`endif
        end
      end
      S_LOAD: begin
        if (shift) begin
          sr_next  = {1'b0, sr_reg[7:1]};
          occ_next = occ_reg - 4'd1;
          cnt_next = cnt_reg + ONE;
`ifdef BNN_PARAM_LOADER_VERIFY_EN
          if (sr_reg[0] && (ones_load_reg != TERM))
            ones_load_next = ones_load_reg + ONE;
`endif
        end
        if (byte_ready && byte_valid) begin
          sr_next  = byte_data;
          occ_next = 4'd8;
        end
        if (last_shift) begin
          // Leftover bits of the final byte are dropped; sr stays zero so
          // chain_param idles low.
          sr_next  = '0;
          occ_next = '0;
`ifdef BNN_PARAM_LOADER_VERIFY_EN
          state_next = S_VERIFY;
          cnt_next   = '0;
`else
          state_next = S_DONE;
          done_next  = 1'b1;
`endif
        end
      end
`ifdef BNN_PARAM_LOADER_VERIFY_EN
      S_VERIFY: begin
        cnt_next = cnt_reg + ONE;
        if (chain_tail && (ones_tail_reg != TERM))
          ones_tail_next = ones_tail_reg + ONE;
        if (cnt_reg == LAST) begin
          state_next = S_DONE;
          done_next  = 1'b1;
          error_next = (ones_tail_next != ones_load_reg);
        end
      end
`endif
      default: ;
    endcase

    setup_next = (state_next == S_LOAD) && (occ_next != 4'd0);
    busy_next  = (state_next == S_LOAD);
`ifdef BNN_PARAM_LOADER_VERIFY_EN
    if (state_next == S_VERIFY) begin
      setup_next = 1'b1;
      busy_next  = 1'b1;
    end
`endif
  end

  assign chain_setup = setup_reg;
  assign busy        = busy_reg;
  assign done        = done_reg;
  assign bit_count   = cnt_reg;

`ifdef BNN_PARAM_LOADER_VERIFY_EN
  // During verify the tail feeds the head directly so the chain recirculates.
  assign chain_param = (state_reg == S_VERIFY) ? chain_tail : sr_reg[0];
  assign error       = error_reg;
`else
  logic unused_tail;
  assign unused_tail = chain_tail;
  assign chain_param = sr_reg[0];
  assign error       = 1'b0;
`endif

endmodule

// File: tb/tb_bnn_param_loader.sv
// Testbench for bnn_param_loader: randomized byte streams checked against a
// bit-stream model and a behavioural chain shift register.
`timescale 1ns/1ps
module tb_bnn_param_loader;
  localparam int CB   = 384;
  localparam int CW   = 9;
  localparam int CB20 = 20;
  localparam int CW20 = 5;

  logic clk = 1'b0;
  logic reset, start, byte_valid;
  logic [7:0] byte_data;
  logic byte_ready, chain_setup, chain_param, chain_tail, busy, done, error;
  logic [CW-1:0] bit_count;

  logic start20, byte_valid20;
  logic [7:0] byte_data20;
  logic byte_ready20, chain_setup20, chain_param20, busy20, done20, error20;
  logic chain_tail20 = 1'b0;
  logic [CW20-1:0] bit_count20;

  always #5 clk = ~clk;

  bnn_param_loader #(.CHAIN_BITS(CB), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .byte_data(byte_data),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .chain_setup(chain_setup),
    .chain_param(chain_param), .chain_tail(chain_tail), .busy(busy),
    .done(done), .error(error), .bit_count(bit_count)
  );

  bnn_param_loader #(.CHAIN_BITS(CB20), .CNT_W(CW20)) dut20 (
    .clk(clk), .reset(reset), .start(start20), .byte_data(byte_data20),
    .byte_valid(byte_valid20), .byte_ready(byte_ready20), .chain_setup(chain_setup20),
    .chain_param(chain_param20), .chain_tail(chain_tail20), .busy(busy20),
    .done(done20), .error(error20), .bit_count(bit_count20)
  );

  // Behavioural chain: shifts param in at the head whenever setup is high.
  int cyc_now = 0;
  bit shifted_q[$];
  int shift_cyc_q[$];
  bit bits20_q[$];
  logic [CB-1:0] chain = '0;
  logic corrupt = 1'b0;
  assign chain_tail = chain[CB-1];

  always @(posedge clk) begin
    cyc_now <= cyc_now + 1;
    if (chain_setup) begin
      shifted_q.push_back(chain_param);
      shift_cyc_q.push_back(cyc_now);
      chain <= {chain[CB-2:0], chain_param ^ corrupt};
    end
    if (chain_setup20) bits20_q.push_back(chain_param20);
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  logic [7:0] data_q [48];
  int gap_q [48];

  task automatic run_load(input string name, input int abort_at, input int restart_at,
                          input int corrupt_at);
    int s_cyc, d_cyc, base, idx, gap, bc_err, cyc, loaded, exp_bc, gap_sum;
    int exp_done, exp_sh, exp_err, bit_err, chain_err, n_sh, bubble, first_lat;
    bit acc, seen_done;
    logic [7:0] b;
    gap_sum = 0;
    for (int k = 0; k < 47; k++) gap_sum += gap_q[k];
    exp_done = 2 + CB + gap_sum;
    exp_sh   = CB;
    exp_err  = 0;
`ifdef BNN_PARAM_LOADER_VERIFY_EN
    exp_done = exp_done + CB;
    exp_sh   = 2 * CB;
    exp_err  = (corrupt_at >= 0) ? 1 : 0;
`endif
    base = shifted_q.size();
    @(negedge clk);
    start = 1'b1;
    s_cyc = cyc_now;
    @(negedge clk);
    start = 1'b0;
    idx = 0; gap = 0; bc_err = 0; cyc = 0; seen_done = 1'b0; d_cyc = 0;
    while (!seen_done && cyc < 4000) begin
      loaded = shifted_q.size() - base;
      if (done) begin
        seen_done = 1'b1;
        d_cyc = cyc_now;
      end else begin
        exp_bc = loaded;
`ifdef BNN_PARAM_LOADER_VERIFY_EN
        if (loaded >= CB) exp_bc = loaded - CB;
`endif
        if (int'(bit_count) != exp_bc) bc_err++;
        if (abort_at > 0 && loaded == abort_at) begin
          reset = 1'b1; byte_valid = 1'b0; start = 1'b0;
          @(negedge clk);
          reset = 1'b0;
          check_val({name, "_bitcnt_before_rst"}, bc_err, 0);
          check_val({name, "_rst_busy"}, busy, 0);
          check_val({name, "_rst_setup"}, chain_setup, 0);
          check_val({name, "_rst_bitcount"}, bit_count, 0);
          check_val({name, "_rst_ready"}, byte_ready, 0);
          check_val({name, "_rst_done"}, done, 0);
          $display("load %s: reset after %0d bits, busy=%0d bit_count=%0d", name, loaded, busy, bit_count);
          return;
        end
        start   = (cyc == restart_at);
        corrupt = (corrupt_at >= 0 && loaded == corrupt_at);
        acc = 1'b0;
        if (idx < 48) begin
          b = data_q[idx];
          byte_data = b;
          if (gap > 0) begin
            byte_valid = 1'b0;
            if (byte_ready) gap--;
          end else if (!byte_ready) begin
            byte_valid = 1'($urandom_range(0, 1));
          end else begin
            byte_valid = 1'b1;
          end
          acc = byte_valid && byte_ready;
        end else begin
          byte_valid = 1'b0;
        end
        @(negedge clk);
        if (acc) begin
          idx++;
          gap = gap_q[idx-1];
        end
        cyc++;
      end
    end
    start = 1'b0; byte_valid = 1'b0; corrupt = 1'b0;
    n_sh = shifted_q.size() - base;
    bit_err = 0; chain_err = 0;
    for (int i = 0; i < CB; i++) begin
      b = data_q[i/8];
      if (base + i >= shifted_q.size() || shifted_q[base+i] != b[i%8]) bit_err++;
`ifdef BNN_PARAM_LOADER_VERIFY_EN
      if (corrupt_at < 0 && (base + CB + i >= shifted_q.size() || shifted_q[base+CB+i] != b[i%8])) bit_err++;
`endif
      if (chain[CB-1-i] != b[i%8]) chain_err++;
    end
    bubble    = (n_sh >= CB) ? shift_cyc_q[base+CB-1] - shift_cyc_q[base] + 1 - CB : -1;
    first_lat = (n_sh > 0) ? shift_cyc_q[base] - s_cyc : -1;
    check_val({name, "_done_seen"}, seen_done, 1);
    check_val({name, "_done_cycle"}, d_cyc - s_cyc, exp_done);
    check_val({name, "_first_shift"}, first_lat, 2);
    check_val({name, "_n_shifts"}, n_sh, exp_sh);
    check_val({name, "_bubbles"}, bubble, gap_sum);
    check_val({name, "_bits"}, bit_err, 0);
    if (corrupt_at < 0) check_val({name, "_chain"}, chain_err, 0);
    check_val({name, "_bitcnt_track"}, bc_err, 0);
    check_val({name, "_end_busy"}, busy, 0);
    check_val({name, "_end_setup"}, chain_setup, 0);
    check_val({name, "_end_ready"}, byte_ready, 0);
    check_val({name, "_end_bitcount"}, bit_count, CB);
    check_val({name, "_end_error"}, error, exp_err);
    $display("load %s: done@+%0d shifts=%0d bubbles=%0d bit_err=%0d chain_err=%0d error=%0d",
             name, d_cyc - s_cyc, n_sh, bubble, bit_err, chain_err, error);
  endtask

  initial begin
    logic [7:0] d20 [4];
    int n_acc, rdy_err, cyc, bit_err20, exp_sh20;
    bit acc;
    d20[0] = 8'hFF; d20[1] = 8'h00; d20[2] = 8'h0F; d20[3] = 8'hAA;
    reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    start20 = 1'b0; byte_valid20 = 1'b0; byte_data20 = 8'h00;
    repeat (3) @(negedge clk);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_error", error, 0);
    check_val("rst_setup", chain_setup, 0);
    check_val("rst_param", chain_param, 0);
    check_val("rst_ready", byte_ready, 0);
    check_val("rst_bitcount", bit_count, 0);
    check_val("rst_done20", done20, 0);
    $display("reset: busy=%0d done=%0d ready=%0d bit_count=%0d", busy, done, byte_ready, bit_count);
    reset = 1'b0;

    for (int k = 0; k < 48; k++) begin data_q[k] = 8'($urandom); gap_q[k] = 0; end
    run_load("abort37", 37, -1, -1);

    for (int k = 0; k < 48; k++) begin data_q[k] = 8'hA5; gap_q[k] = 0; end
    run_load("a5_stream", 0, -1, -1);
    repeat (3) @(negedge clk);
    check_val("done_held", done, 1);

    gap_q[9] = 5;
    run_load("a5_bubble", 0, -1, -1);

    for (int k = 0; k < 48; k++) begin data_q[k] = 8'($urandom); gap_q[k] = $urandom_range(0, 3); end
    run_load("rand_restart", 0, $urandom_range(20, 200), -1);

    for (int k = 0; k < 48; k++) begin data_q[k] = 8'($urandom); gap_q[k] = $urandom_range(0, 2); end
    run_load("rand_corrupt", 0, -1, $urandom_range(0, CB - 1));

    // Short chain: third byte is cut after 4 bits, a fourth byte is never taken.
    @(negedge clk);
    start20 = 1'b1;
    @(negedge clk);
    start20 = 1'b0;
    n_acc = 0; rdy_err = 0; cyc = 0;
    while (!done20 && cyc < 200) begin
      if (n_acc >= 3 && byte_ready20) rdy_err++;
      byte_data20  = d20[(n_acc > 3) ? 3 : n_acc];
      byte_valid20 = 1'b1;
      acc = byte_ready20;
      @(negedge clk);
      if (acc) n_acc++;
      cyc++;
    end
    byte_valid20 = 1'b0;
    exp_sh20 = CB20;
`ifdef BNN_PARAM_LOADER_VERIFY_EN
    exp_sh20 = 2 * CB20;
`endif
    bit_err20 = 0;
    for (int i = 0; i < CB20; i++) begin
      if (i >= bits20_q.size() || bits20_q[i] != ((i < 8 || i >= 16) ? 1'b1 : 1'b0)) bit_err20++;
    end
    check_val("c20_done", done20, 1);
    check_val("c20_accepts", n_acc, 3);
    check_val("c20_ready_after3", rdy_err, 0);
    check_val("c20_shifts", bits20_q.size(), exp_sh20);
    check_val("c20_bits", bit_err20, 0);
    check_val("c20_bitcount", bit_count20, CB20);
    $display("load c20: accepts=%0d shifts=%0d bit_err=%0d bit_count=%0d",
             n_acc, bits20_q.size(), bit_err20, bit_count20);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
